// File: rtl/regfile_arbiter_pkg.sv
// Shared definitions for the register-file arbiter: FSM encoding, requester
// indices and a one-hot to index helper.
package regfile_arbiter_pkg;

    typedef enum logic [1:0] {StIdle, StGrant, StGap} arbState_e;

    localparam int unsigned REQ_ALU = 0;
    localparam int unsigned REQ_LS  = 1;
    localparam int unsigned REQ_IF  = 2;

    function automatic int unsigned ohToIdx(input logic [31:0] oh);
        ohToIdx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) ohToIdx = i;
        end
    endfunction

endpackage

// File: rtl/regfile_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request searching upward
// (with wrap) from lastOwner+1, returned as a one-hot vector.
module rr_pick #(
    parameter int unsigned NREQ = 3,
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   lastOwner,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    logic [IW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        // Offset NREQ wraps back to lastOwner itself, so it is tried last.
        for (int unsigned off = 1; off <= NREQ; off++) begin
            idx = IW'((32'(lastOwner) + off) % NREQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing the single-port register file between the ALU,
// load/store and fetch sequencers, with a one-cycle gap and a hold limit.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned AW       = 4,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  rd_en,
    input  logic [NREQ-1:0]  wr_en,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]  gnt,
    output logic             busy,
    output logic             rf_RrEn,
    output logic             rf_RwEn,
    output logic [AW-1:0]    rf_addr,
    output logic [DW-1:0]    rf_wdata
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    arbState_e       stateQ, stateD;
    logic [NREQ-1:0] gntQ, gntD;
    logic [IW-1:0]   ownerQ, ownerD;
    logic [IW-1:0]   lastOwnerQ, lastOwnerD;
    logic [HW-1:0]   holdCntQ, holdCntD;
    logic [NREQ-1:0] pick;
    logic            pickValid;
    logic            otherReq;

    rr_pick #(
        .NREQ(NREQ)
    ) uPick (
        .req      (req),
        .lastOwner(lastOwnerQ),
        .pick     (pick),
        .valid    (pickValid)
    );

    assign otherReq = |(req & ~gntQ);

    always_comb begin
        stateD     = stateQ;
        gntD       = gntQ;
        ownerD     = ownerQ;
        lastOwnerD = lastOwnerQ;
        holdCntD   = holdCntQ;
        unique case (stateQ)
            // The gap cycle already arbitrates, so the new owner appears right after it.
            StIdle, StGap: begin
                if (pickValid) begin
                    stateD   = StGrant;
                    gntD     = pick;
                    ownerD   = IW'(ohToIdx(32'(pick)));
                    holdCntD = '0;
                end else begin
                    stateD = StIdle;
                    gntD   = '0;
                end
            end
            StGrant: begin
                if (holdCntQ != HW'(MAX_HOLD)) holdCntD = holdCntQ + HW'(1);
                if (!req[ownerQ] || (holdCntQ == HW'(MAX_HOLD) && otherReq)) begin
                    stateD     = StGap;
                    gntD       = '0;
                    // Recorded on entry to the gap so the gap-cycle search skips this owner.
                    lastOwnerD = ownerQ;
                end
            end
            default: begin
                stateD = StIdle;
                gntD   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ     <= StIdle;
            gntQ       <= '0;
            ownerQ     <= '0;
            lastOwnerQ <= IW'(NREQ - 1);
            holdCntQ   <= '0;
        end else begin
            stateQ     <= stateD;
            gntQ       <= gntD;
            ownerQ     <= ownerD;
            lastOwnerQ <= lastOwnerD;
            holdCntQ   <= holdCntD;
        end
    end

    always_comb begin
        rf_RrEn  = 1'b0;
        rf_RwEn  = 1'b0;
        rf_addr  = '0;
        rf_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rf_RrEn  = rf_RrEn | (gntQ[i] & rd_en[i]);
            rf_RwEn  = rf_RwEn | (gntQ[i] & wr_en[i]);
            rf_addr  = rf_addr | (addr[i*AW +: AW] & {AW{gntQ[i]}});
            rf_wdata = rf_wdata | (wdata[i*DW +: DW] & {DW{gntQ[i]}});
        end
    end

    assign gnt  = gntQ;
    assign busy = (stateQ == StGrant);

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: per-cycle expectations go through a
// scoreboard queue and are checked with immediate assertions.
module tb_regfile_arbiter;
    import regfile_arbiter_pkg::*;

    localparam int unsigned NREQ     = 3;
    localparam int unsigned AW       = 4;
    localparam int unsigned DW       = 8;
    localparam int unsigned MAX_HOLD = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   rd_en;
    logic [NREQ-1:0]   wr_en;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              rf_RrEn;
    logic              rf_RwEn;
    logic [AW-1:0]     rf_addr;
    logic [DW-1:0]     rf_wdata;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic            busy;
        logic            rren;
        logic            rwen;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   wdata;
    } expT;

    expT sb[$];
    int  total = 0;
    int  bad   = 0;

    regfile_arbiter #(
        .NREQ    (NREQ),
        .AW      (AW),
        .DW      (DW),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .rd_en   (rd_en),
        .wr_en   (wr_en),
        .addr    (addr),
        .wdata   (wdata),
        .gnt     (gnt),
        .busy    (busy),
        .rf_RrEn (rf_RrEn),
        .rf_RwEn (rf_RwEn),
        .rf_addr (rf_addr),
        .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic setRq(input int unsigned i, input logic r, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = r;
        rd_en[i]          = rd;
        wr_en[i]          = wr;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    // Port contents implied by a given grant and the inputs currently driven.
    function automatic expT model(input logic [NREQ-1:0] g);
        expT e;
        e      = '0;
        e.gnt  = g;
        e.busy = |g;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (g[i]) begin
                e.rren  = rd_en[i];
                e.rwen  = wr_en[i];
                e.addr  = addr[i*AW +: AW];
                e.wdata = wdata[i*DW +: DW];
            end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, got, want);
        end
    endtask

    task automatic step(input logic [NREQ-1:0] expGnt, input string tag);
        expT e;
        sb.push_back(model(expGnt));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(tag, "gnt", 32'(gnt), 32'(e.gnt));
        chk(tag, "busy", 32'(busy), 32'(e.busy));
        chk(tag, "RrEn", 32'(rf_RrEn), 32'(e.rren));
        chk(tag, "RwEn", 32'(rf_RwEn), 32'(e.rwen));
        chk(tag, "addr", 32'(rf_addr), 32'(e.addr));
        chk(tag, "wdata", 32'(rf_wdata), 32'(e.wdata));
    endtask

    task automatic stepN(input int n, input logic [NREQ-1:0] expGnt, input string tag);
        for (int k = 0; k < n; k++) step(expGnt, tag);
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        rd_en = '0;
        wr_en = '0;
        addr  = '0;
        wdata = '0;

        // Reset state, then idle.
        step(3'b000, "rst");
        step(3'b000, "rst");
        reset = 1'b0;
        step(3'b000, "idle");

        // Single request from the ALU sequencer.
        setRq(REQ_ALU, 1'b1, 1'b1, 1'b0, 4'h5, 8'h11);
        step(3'b001, "single");
        chk("single", "RrEn_const", 32'(rf_RrEn), 32'd1);
        chk("single", "addr_const", 32'(rf_addr), 32'h5);
        step(3'b001, "single_hold");
        setRq(REQ_ALU, 1'b0, 1'b1, 1'b0, 4'h5, 8'h11);
        step(3'b000, "single_rel");
        step(3'b000, "single_idle");

        // All three requesting straight out of reset: 0, gap, 1, gap, 2.
        reset = 1'b1;
        step(3'b000, "rst2");
        reset = 1'b0;
        setRq(REQ_ALU, 1'b1, 1'b1, 1'b0, 4'h1, 8'h11);
        setRq(REQ_LS,  1'b1, 1'b0, 1'b1, 4'h2, 8'h22);
        setRq(REQ_IF,  1'b1, 1'b1, 1'b1, 4'h3, 8'h33);
        step(3'b001, "rr0");
        setRq(REQ_ALU, 1'b0, 1'b1, 1'b0, 4'h1, 8'h11);
        step(3'b000, "rr_gap0");
        step(3'b010, "rr1");
        setRq(REQ_LS, 1'b0, 1'b0, 1'b1, 4'h2, 8'h22);
        step(3'b000, "rr_gap1");
        step(3'b100, "rr2");
        setRq(REQ_IF, 1'b0, 1'b1, 1'b1, 4'h3, 8'h33);
        step(3'b000, "rr_gap2");
        step(3'b000, "rr_idle");

        // Starvation guard: owner 0 held for MAX_HOLD+1 cycles, then fetch.
        setRq(REQ_ALU, 1'b1, 1'b1, 1'b0, 4'h4, 8'h44);
        step(3'b001, "sg");
        step(3'b001, "sg");
        setRq(REQ_IF, 1'b1, 1'b0, 1'b1, 4'h9, 8'h99);
        stepN(MAX_HOLD - 1, 3'b001, "sg_hold");
        step(3'b000, "sg_gap");
        step(3'b100, "sg_if");
        setRq(REQ_IF, 1'b0, 1'b0, 1'b1, 4'h9, 8'h99);
        step(3'b000, "sg_gap2");
        step(3'b001, "sg_back");
        setRq(REQ_ALU, 1'b0, 1'b1, 1'b0, 4'h4, 8'h44);
        step(3'b000, "sg_rel");
        step(3'b000, "sg_idle");

        // Guard not triggered without competition.
        setRq(REQ_ALU, 1'b1, 1'b1, 1'b0, 4'h6, 8'h66);
        stepN(20, 3'b001, "noguard");
        setRq(REQ_ALU, 1'b0, 1'b1, 1'b0, 4'h6, 8'h66);
        step(3'b000, "ng_rel");
        step(3'b000, "ng_idle");

        // Isolation: load/store write strobe must not leak while ALU owns the port.
        setRq(REQ_ALU, 1'b1, 1'b1, 1'b0, 4'h7, 8'h3C);
        setRq(REQ_LS,  1'b0, 1'b0, 1'b1, 4'hF, 8'hAA);
        step(3'b001, "iso");
        setRq(REQ_LS, 1'b1, 1'b0, 1'b1, 4'hF, 8'hAA);
        stepN(3, 3'b001, "iso_pend");
        chk("iso", "RwEn_const", 32'(rf_RwEn), 32'd0);
        chk("iso", "wdata_const", 32'(rf_wdata), 32'h3C);
        setRq(REQ_ALU, 1'b0, 1'b1, 1'b0, 4'h7, 8'h3C);
        step(3'b000, "iso_gap");
        step(3'b010, "iso_ls");
        chk("iso_ls", "RwEn_const", 32'(rf_RwEn), 32'd1);
        chk("iso_ls", "wdata_const", 32'(rf_wdata), 32'hAA);

        // Reset in the middle of the load/store write grant.
        reset = 1'b1;
        step(3'b000, "rst_mid");
        chk("rst_mid", "RwEn_const", 32'(rf_RwEn), 32'd0);
        reset = 1'b0;
        setRq(REQ_IF, 1'b1, 1'b1, 1'b1, 4'h3, 8'h5A);
        step(3'b010, "rst_ls_first");
        setRq(REQ_LS, 1'b0, 1'b0, 1'b1, 4'hF, 8'hAA);
        step(3'b000, "rst_gap");
        step(3'b100, "both_en");
        chk("both_en", "RrEn_const", 32'(rf_RrEn), 32'd1);
        chk("both_en", "RwEn_const", 32'(rf_RwEn), 32'd1);
        setRq(REQ_IF, 1'b0, 1'b1, 1'b1, 4'h3, 8'h5A);
        step(3'b000, "end_gap");
        step(3'b000, "end_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
